// File: rtl/spl_tx_arbiter_if.sv
// Bundles the requester-side and SPL TX-side signals of the TX arbiter.
// The master modport is the requester/SPL environment; the slave modport is the arbiter.
interface spl_tx_arbiter_if #(
  parameter int N_REQ  = 3,
  parameter int HDR_W  = 99,
  parameter int DATA_W = 512
);
  localparam int SRC_W = $clog2(N_REQ);

  logic [N_REQ-1:0]        req_valid;
  logic [N_REQ-1:0]        req_ready;
  logic [N_REQ-1:0]        req_is_write;
  logic [N_REQ*HDR_W-1:0]  req_hdr;
  logic [N_REQ*DATA_W-1:0] req_data;
  logic                    tx_almost_full;
  logic                    tx_valid;
  logic                    tx_is_write;
  logic [HDR_W-1:0]        tx_hdr;
  logic [DATA_W-1:0]       tx_data;
  logic [SRC_W-1:0]        tx_src;

  modport master (
    output req_valid, req_is_write, req_hdr, req_data, tx_almost_full,
    input  req_ready, tx_valid, tx_is_write, tx_hdr, tx_data, tx_src
  );

  modport slave (
    input  req_valid, req_is_write, req_hdr, req_data, tx_almost_full,
    output req_ready, tx_valid, tx_is_write, tx_hdr, tx_data, tx_src
  );
endinterface

// File: rtl/spl_tx_arbiter.sv
// Shares the SPL TX request channel: requester 0 has priority up to a burst limit,
// the remaining requesters are served round-robin; the winning beat is registered.
module spl_tx_arbiter #(
  parameter int N_REQ        = 3,
  parameter int HDR_W        = 99,
  parameter int DATA_W       = 512,
  parameter int MAX_HI_BURST = 4
) (
  input logic            clk,
  input logic            resetb,
  spl_tx_arbiter_if.slave bus
);
  localparam int SRC_W = $clog2(N_REQ);
  localparam int CNT_W = 4;

  logic [SRC_W-1:0] rr_ptr;
  logic [CNT_W-1:0] hi_burst_cnt;
  logic             others_valid;
  logic             grant_any;
  logic [SRC_W-1:0] grant_idx;
  logic [SRC_W:0]   cand;
  logic [N_REQ-1:0] grant_oh;

  // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    grant_any    = 1'b0;
    grant_idx    = '0;
    cand         = '0;
    others_valid = |bus.req_valid[N_REQ-1:1];
    if (!resetb && !bus.tx_almost_full) begin
      if (bus.req_valid[0] && (!others_valid || hi_burst_cnt < CNT_W'(MAX_HI_BURST))) begin
        grant_any = 1'b1;
        grant_idx = '0;
      end else begin
        // Cyclic search over 1..N_REQ-1 starting at rr_ptr; first hit wins.
        for (int k = 0; k < N_REQ - 1; k++) begin
          cand = {1'b0, rr_ptr} + (SRC_W + 1)'(k);
          if (cand > (SRC_W + 1)'(N_REQ - 1)) cand = cand - (SRC_W + 1)'(N_REQ - 1);
          if (!grant_any && bus.req_valid[cand[SRC_W-1:0]]) begin
            grant_any = 1'b1;
            grant_idx = cand[SRC_W-1:0];
          end
        end
        if (!grant_any && bus.req_valid[0]) begin
          grant_any = 1'b1;
          grant_idx = '0;
        end
      end
    end
  end

  always_comb begin
    grant_oh = '0;
    if (grant_any) grant_oh[grant_idx] = 1'b1;
  end

  assign bus.req_ready = grant_oh;

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or posedge resetb) begin
    if (resetb) begin
      bus.tx_valid    <= 1'b0;
      bus.tx_is_write <= 1'b0;
      bus.tx_hdr      <= '0;
      bus.tx_data     <= '0;
      bus.tx_src      <= '0;
      rr_ptr          <= SRC_W'(1);
      hi_burst_cnt    <= '0;
    end else begin
      bus.tx_valid <= grant_any;
      if (grant_any) begin
        bus.tx_is_write <= bus.req_is_write[grant_idx];
        bus.tx_hdr      <= bus.req_hdr[int'(grant_idx) * HDR_W +: HDR_W];
        bus.tx_data     <= bus.req_is_write[grant_idx]
                           ? bus.req_data[int'(grant_idx) * DATA_W +: DATA_W] : '0;
        bus.tx_src      <= grant_idx;
        if (grant_idx == '0) begin
          // Only count requester-0 grants that actually delay someone else.
          if (!others_valid)                                 hi_burst_cnt <= '0;
          else if (hi_burst_cnt != CNT_W'(MAX_HI_BURST))     hi_burst_cnt <= hi_burst_cnt + 1'b1;
        end else begin
          hi_burst_cnt <= '0;
          rr_ptr       <= (grant_idx == SRC_W'(N_REQ - 1)) ? SRC_W'(1) : grant_idx + 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_spl_tx_arbiter.sv
// Self-checking bench for spl_tx_arbiter: a reference arbitration model predicts grants,
// expected TX beats are queued at grant time and compared when the registered beat appears.
module tb_spl_tx_arbiter;
  localparam int N_REQ        = 3;
  localparam int HDR_W        = 99;
  localparam int DATA_W       = 512;
  localparam int MAX_HI_BURST = 4;

  typedef struct {
    logic              is_write;
    logic [HDR_W-1:0]  hdr;
    logic [DATA_W-1:0] data;
    int                src;
  } beat_t;

  logic clk;
  logic resetb;

  spl_tx_arbiter_if #(.N_REQ(N_REQ), .HDR_W(HDR_W), .DATA_W(DATA_W)) bus ();

  spl_tx_arbiter #(
    .N_REQ(N_REQ), .HDR_W(HDR_W), .DATA_W(DATA_W), .MAX_HI_BURST(MAX_HI_BURST)
  ) dut (
    .clk   (clk),
    .resetb(resetb),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [N_REQ-1:0]  valid_v;
  logic [N_REQ-1:0]  wr_v;
  logic [HDR_W-1:0]  hdr_v  [N_REQ];
  logic [DATA_W-1:0] data_v [N_REQ];
  logic              afull;

  beat_t sb[$];
  int    glog[$];
  int    m_rr;
  int    m_cnt;

  task automatic check(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < N_REQ; i++) begin
      bus.req_hdr[i*HDR_W +: HDR_W]    = hdr_v[i];
      bus.req_data[i*DATA_W +: DATA_W] = data_v[i];
    end
    bus.req_valid      = valid_v;
    bus.req_is_write   = wr_v;
    bus.tx_almost_full = afull;
  endtask

  function automatic int model_grant();
    bit others;
    int idx;
    if (resetb || afull) return -1;
    others = |valid_v[N_REQ-1:1];
    if (valid_v[0] && (!others || m_cnt < MAX_HI_BURST)) return 0;
    for (int k = 0; k < N_REQ - 1; k++) begin
      idx = m_rr + k;
      if (idx > N_REQ - 1) idx -= N_REQ - 1;
      if (valid_v[idx]) return idx;
    end
    if (valid_v[0]) return 0;
    return -1;
  endfunction

  function automatic int decode_ready(input logic [N_REQ-1:0] r);
    for (int i = 0; i < N_REQ; i++) if (r[i]) return i;
    return -1;
  endfunction

  task automatic model_reset();
    m_rr  = 1;
    m_cnt = 0;
    sb.delete();
  endtask

  // Entered shortly after a rising edge with inputs driven; leaves in the same phase one cycle later.
  task automatic cycle();
    beat_t e;
    int    g;
    bit    others;
    logic [N_REQ-1:0] exp_ready;
    @(negedge clk);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("tx_valid", DATA_W'(bus.tx_valid), DATA_W'(1));
      check("tx_is_write", DATA_W'(bus.tx_is_write), DATA_W'(e.is_write));
      check("tx_hdr", DATA_W'(bus.tx_hdr), DATA_W'(e.hdr));
      check("tx_data", bus.tx_data, e.data);
      check("tx_src", DATA_W'(bus.tx_src), DATA_W'(e.src));
    end else begin
      check("tx_idle", DATA_W'(bus.tx_valid), DATA_W'(0));
    end
    g         = model_grant();
    exp_ready = (g >= 0) ? N_REQ'(1) << g : '0;
    check("req_ready", DATA_W'(bus.req_ready), DATA_W'(exp_ready));
    glog.push_back(decode_ready(bus.req_ready));
    others = |valid_v[N_REQ-1:1];
    if (g >= 0) begin
      e.is_write = wr_v[g];
      e.hdr      = hdr_v[g];
      e.data     = wr_v[g] ? data_v[g] : '0;
      e.src      = g;
      sb.push_back(e);
      if (g == 0) m_cnt = others ? ((m_cnt < MAX_HI_BURST) ? m_cnt + 1 : m_cnt) : 0;
      else begin
        m_cnt = 0;
        m_rr  = (g + 1 > N_REQ - 1) ? 1 : g + 1;
      end
    end
    @(posedge clk);
    #1;
    // An accepted requester moves on to a fresh request.
    if (g >= 0) begin
      hdr_v[g]  = hdr_v[g] + HDR_W'('h100);
      data_v[g] = data_v[g] + DATA_W'('h1_0000);
    end
    drive();
  endtask

  int burst_exp [12] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 2, 0, 0};

  initial begin
    resetb  = 1'b1;
    afull   = 1'b0;
    valid_v = '1;
    wr_v    = '1;
    for (int i = 0; i < N_REQ; i++) begin
      hdr_v[i]  = HDR_W'(i * 'h11 + 'h1000);
      data_v[i] = DATA_W'(i * 'h777 + 'hABC0000);
    end
    drive();
    model_reset();
    #1;
    check("rst_tx_valid", DATA_W'(bus.tx_valid), DATA_W'(0));
    check("rst_tx_is_write", DATA_W'(bus.tx_is_write), DATA_W'(0));
    check("rst_tx_hdr", DATA_W'(bus.tx_hdr), DATA_W'(0));
    check("rst_tx_data", bus.tx_data, DATA_W'(0));
    check("rst_tx_src", DATA_W'(bus.tx_src), DATA_W'(0));
    check("rst_req_ready", DATA_W'(bus.req_ready), DATA_W'(0));
    @(posedge clk);
    @(posedge clk);
    #1;
    resetb = 1'b0;
    drive();

    // Burst limit with all requesters continuously valid.
    glog.delete();
    for (int c = 0; c < 12; c++) cycle();
    for (int k = 0; k < 12; k++) check($sformatf("burst_seq[%0d]", k), DATA_W'(glog[k]), DATA_W'(burst_exp[k]));
    valid_v = '0;
    drive();
    cycle();

    // Single write from requester 2.
    valid_v   = 3'b100;
    wr_v[2]   = 1'b1;
    hdr_v[2]  = HDR_W'('h5A);
    data_v[2] = DATA_W'('hDEAD);
    drive();
    glog.delete();
    cycle();
    check("single_grant", DATA_W'(glog[0]), DATA_W'(2));
    valid_v = '0;
    drive();
    cycle();

    // Read from requester 1 with non-zero data on the bus.
    valid_v   = 3'b010;
    wr_v[1]   = 1'b0;
    data_v[1] = DATA_W'('hFFFF);
    drive();
    cycle();
    valid_v = '0;
    drive();
    cycle();

    // Backpressure in cycles 3..6 with everyone valid.
    valid_v = '1;
    wr_v    = 3'b101;
    glog.delete();
    for (int c = 1; c <= 10; c++) begin
      afull = (c >= 3 && c <= 6);
      drive();
      cycle();
    end
    for (int c = 3; c <= 6; c++) check($sformatf("afull_no_grant[%0d]", c), DATA_W'(glog[c-1]), DATA_W'(-1));
    afull   = 1'b0;
    valid_v = '0;
    drive();
    cycle();

    // Round-robin between requesters 1 and 2.
    valid_v = 3'b110;
    drive();
    glog.delete();
    for (int c = 0; c < 10; c++) cycle();
    for (int k = 1; k < 10; k++) check($sformatf("rr_alt[%0d]", k), DATA_W'(glog[k] != glog[k-1]), DATA_W'(1));
    check("rr_first_valid", DATA_W'(glog[0] == 1 || glog[0] == 2), DATA_W'(1));
    valid_v = '0;
    drive();
    cycle();

    // Reset while a beat is registered.
    valid_v = 3'b010;
    drive();
    cycle();
    check("mid_pre_tx_valid", DATA_W'(bus.tx_valid), DATA_W'(1));
    #2;
    resetb = 1'b1;
    #1;
    check("mid_rst_tx_valid", DATA_W'(bus.tx_valid), DATA_W'(0));
    check("mid_rst_req_ready", DATA_W'(bus.req_ready), DATA_W'(0));
    model_reset();
    @(posedge clk);
    #1;
    check("mid_rst_req_ready_hold", DATA_W'(bus.req_ready), DATA_W'(0));
    resetb  = 1'b0;
    valid_v = 3'b110;
    drive();
    glog.delete();
    cycle();
    check("post_rst_first_grant", DATA_W'(glog[0]), DATA_W'(1));
    valid_v = '0;
    drive();
    cycle();
    cycle();

    check("sb_drained", DATA_W'(sb.size()), DATA_W'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
